miriscv_csr_file: RTL and testbench
===================================

# miriscv_csr_file

Machine-mode control/status register file for the miriscv core, sitting beside the decoder and register file. It:
- executes csrrw/csrrs/csrrc;
- holds mstatus, mie, mip, mtvec, mepc, mcause, mscratch and mhartid;
- performs trap entry and mret state updates;
- computes the trap vector (direct or vectored);
- raises a masked interrupt request to the core.

Optional 64-bit mcycle/minstret counters are compiled in by macro.

## Interface
Parameters:
- NUM_IRQ, 16 — interrupt lines, 1..32; mie/mip bits [NUM_IRQ-1:0], upper bits read 0
- MTVEC_RESET, 32'h0000_0000 — mtvec reset value
- HART_ID, 0 — value read from mhartid

Ports:
- Clocking/reset: one clock; reset is synchronous and active-high.
  - clk — in, 1 — clock
  - reset — in, 1 — synchronous, active-high
- CSR access:
  - csr_op_i — in, 2 — 00 none, 01 rw, 10 rs, 11 rc
  - csr_addr_i — in, 12 — CSR address
  - csr_wdata_i — in, 32 — write operand
  - csr_rdata_o — out, 32 — pre-write value of addressed CSR
  - csr_illegal_o — out, 1 — unimplemented address with op≠00
- Trap control:
  - trap_i — in, 1 — take trap this cycle
  - trap_pc_i — in, 32 — pc saved to mepc
  - trap_cause_i — in, 32 — saved to mcause
  - mret_i — in, 1 — return from trap
- Interrupts and retirement:
  - irq_i — in, NUM_IRQ — level interrupt lines
  - instret_i — in, 1 — one instruction retired this cycle
  - irq_req_o — out, 1 — enabled pending interrupt while mstatus.MIE=1
  - irq_id_o — out, 5 — lowest-index enabled pending line
- Register outputs:
  - trap_vector_o — out, 32 — handler address
  - mepc_o — out, 32 — mepc
  - mie_o — out, 32 — mie

## Operation
- Addresses:
  - mstatus 0x300; mie 0x304; mtvec 0x305
  - mscratch 0x340; mepc 0x341; mcause 0x342; mip 0x344
  - mhartid 0xF14
  - counters 0xB00/0xB80/0xB02/0xB82
- Write value for the addressed CSR:
  - rw: wdata
  - rs: old | wdata
  - rc: old & ~wdata
- Field rules:
  - mstatus implements only MIE[3] and MPIE[7]; MPP[12:11] reads 2'b11; other bits read 0 and ignore writes.
  - mepc[1:0] is forced to 0.
  - mip and mhartid are read-only: writes are ignored and not illegal.
- Trap entry (trap_i=1):
  - mepc←trap_pc_i, mcause←trap_cause_i
  - MPIE←MIE, MIE←0
  - any CSR write in the same cycle is suppressed
- mret (mret_i=1, trap_i=0): MIE←MPIE, MPIE←1. A CSR write in the same cycle is suppressed.
- Priority: trap_i > mret_i > CSR write.
- mip: register of irq_i, sampled every cycle.
- irq_req_o = MIE & |(mip & mie), combinational from registers.
- irq_id_o = lowest set bit of mip & mie; 0 when none.
- trap_vector_o:
  - vectored when mtvec[1:0]=01 and trap_cause_i[31]=1: {mtvec[31:2],2'b00} + 4*trap_cause_i[4:0]
  - otherwise (direct): {mtvec[31:2],2'b00}
- Reset values: all CSRs 0 except mtvec=MTVEC_RESET; mip=0, counters=0; all outputs follow, so irq_req_o=0 and csr_illegal_o=0.

## Timing
- csr_rdata_o and csr_illegal_o are combinational in the same cycle; updates land at the next clk edge.
- irq_i to irq_req_o latency: 1 cycle (mip register).
- After a trap, irq_req_o drops the following cycle because MIE=0.
- Reset asserted mid-operation clears everything at that edge and overrides trap_i/mret_i/writes.

## Configuration
- MIRISCV_CSR_COUNTERS_EN defined:
  - 64-bit mcycle increments every cycle.
  - minstret increments when instret_i=1.
  - Both wrap 2^64-1→0.
  - A CSR write to either half replaces that half and suppresses that counter's increment for that cycle.
  - Reads return pre-increment values.
- Undefined: counter addresses are illegal (csr_illegal_o=1), read 0, and instret_i is ignored.

## Structure
- Package miriscv_csr_pkg:
  - CSR address localparams
  - csr_op encoding
  - mstatus bit positions (MIE=3, MPIE=7)
  - mtvec mode constants
- Sub-module miriscv_csr_counter:
  - 64-bit counter with increment enable and lo/hi half write
  - instantiated twice under the macro

## Test plan
- Reset, read mtvec at 0x305 with op=10, wdata=0 → rdata=MTVEC_RESET, illegal=0.
- Access 0x304 twice:
  - rw 0xFFFF_FFFF → reads 0x0000_FFFF (NUM_IRQ=16)
  - then rc 0x0000_00F0 → reads 0x0000_FF0F
- Trap and return:
  - setup: mstatus=0x8, mie bit 5 set, irq_i[5] pulsed high
  - irq_req_o=1, irq_id_o=5 one cycle later
  - trap_i with pc 0x100, cause 0x8000_0005, mtvec=0x201 → trap_vector_o=0x214; next cycle mepc=0x100, mstatus=0x80, irq_req_o=0
  - mret → mstatus=0x88
- Same-cycle trap_i and csr rw to mscratch 0x1234 → mscratch unchanged, trap state updated.
- Read 0x7C0 with op=01 → csr_illegal_o=1, rdata=0; no state change.
- Macro on:
  - write mcycle lo 0xFFFF_FFFF, hi 0xFFFF_FFFF → wraps to 0 next cycle
  - minstret counts exactly 3 after 3 instret_i pulses

Source files
------------

// File: rtl/miriscv_csr_pkg.sv
// miriscv machine-mode CSR file: shared constants.
// Addresses, op encoding, mstatus bits, mtvec modes.
package miriscv_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MINSTRH  = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  function automatic logic [31:0] csr_apply(
    input csr_op_e     op,
    input logic [31:0] old,
    input logic [31:0] wd
  );
    logic [31:0] r;
    r = old;
    unique case (op)
      CSR_OP_RW: r = wd;
      CSR_OP_RS: r = old | wd;
      CSR_OP_RC: r = old & ~wd;
      default:   r = old;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/miriscv_csr_counter.sv
// 64-bit event counter with per-half CSR write.
// A write to either half holds off that cycle's increment.
module miriscv_csr_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [63:0] r_value;

  // count, or load the written half instead
  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
    end else if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) r_value[31:0]  <= wdata_i;
      if (wr_hi_i) r_value[63:32] <= wdata_i;
    end else if (inc_i) begin
      r_value <= r_value + 64'd1;
    end
  end

  assign value_o = r_value;

endmodule

// File: rtl/miriscv_csr_file.sv
// miriscv machine-mode CSR file: access, traps, irqs.
// Define MIRISCV_CSR_COUNTERS_EN for mcycle/minstret.
module miriscv_csr_file
  import miriscv_csr_pkg::*;
#(
  parameter int          NUM_IRQ     = 16,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         csr_op_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [31:0]        csr_wdata_i,
  output logic [31:0]        csr_rdata_o,
  output logic               csr_illegal_o,
  input  logic               trap_i,
  input  logic [31:0]        trap_pc_i,
  input  logic [31:0]        trap_cause_i,
  input  logic               mret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               instret_i,
  output logic               irq_req_o,
  output logic [4:0]         irq_id_o,
  output logic [31:0]        trap_vector_o,
  output logic [31:0]        mepc_o,
  output logic [31:0]        mie_o
);

  logic               r_st_mie;
  logic               r_st_mpie;
  logic [NUM_IRQ-1:0] r_mie;
  logic [NUM_IRQ-1:0] r_mip;
  logic [31:0]        r_mtvec;
  logic [31:0]        r_mepc;
  logic [31:0]        r_mcause;
  logic [31:0]        r_mscratch;

  csr_op_e            w_op;
  logic [31:0]        w_mstatus;
  logic [31:0]        w_mie32;
  logic [31:0]        w_mip32;
  logic [31:0]        w_old;
  logic [31:0]        w_new;
  logic               w_legal;
  logic               w_wr;
  logic [NUM_IRQ-1:0] w_pend;
  logic [4:0]         w_irq_id;
  logic [31:0]        w_base;

`ifdef MIRISCV_CSR_COUNTERS_EN
  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;
`else
  logic        w_unused_instret;
  assign w_unused_instret = instret_i;
`endif

  assign w_op = csr_op_e'(csr_op_i);

  // widen the architectural fields to 32-bit read views
  always_comb begin
    w_mstatus = 32'h0000_1800;
    w_mstatus[MSTATUS_MIE]  = r_st_mie;
    w_mstatus[MSTATUS_MPIE] = r_st_mpie;
    w_mie32 = '0;
    w_mip32 = '0;
    w_mie32[NUM_IRQ-1:0] = r_mie;
    w_mip32[NUM_IRQ-1:0] = r_mip;
  end

  // address decode and pre-write read value
  always_comb begin
    w_old   = '0;
    w_legal = 1'b1;
    unique case (1'b1)
      (csr_addr_i == CSR_MSTATUS):  w_old = w_mstatus;
      (csr_addr_i == CSR_MIE):      w_old = w_mie32;
      (csr_addr_i == CSR_MTVEC):    w_old = r_mtvec;
      (csr_addr_i == CSR_MSCRATCH): w_old = r_mscratch;
      (csr_addr_i == CSR_MEPC):     w_old = r_mepc;
      (csr_addr_i == CSR_MCAUSE):   w_old = r_mcause;
      (csr_addr_i == CSR_MIP):      w_old = w_mip32;
      (csr_addr_i == CSR_MHARTID):  w_old = HART_ID;
`ifdef MIRISCV_CSR_COUNTERS_EN
      (csr_addr_i == CSR_MCYCLE):   w_old = w_mcycle[31:0];
      (csr_addr_i == CSR_MCYCLEH):  w_old = w_mcycle[63:32];
      (csr_addr_i == CSR_MINSTRET): w_old = w_minstret[31:0];
      (csr_addr_i == CSR_MINSTRH):  w_old = w_minstret[63:32];
`endif
      default:                      w_legal = 1'b0;
    endcase
  end

  assign w_new = csr_apply(w_op, w_old, csr_wdata_i);
  assign w_wr  = (w_op != CSR_OP_NONE) & w_legal
               & ~trap_i & ~mret_i;

  assign csr_rdata_o   = w_old;
  assign csr_illegal_o = (w_op != CSR_OP_NONE) & ~w_legal;

  // CSR state: reset > trap > mret > software write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st_mie   <= 1'b0;
      r_st_mpie  <= 1'b0;
      r_mie      <= '0;
      r_mip      <= '0;
      r_mtvec    <= MTVEC_RESET;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mscratch <= '0;
    end else begin
      r_mip <= irq_i;
      if (trap_i) begin
        r_mepc    <= {trap_pc_i[31:2], 2'b00};
        r_mcause  <= trap_cause_i;
        r_st_mpie <= r_st_mie;
        r_st_mie  <= 1'b0;
      end else if (mret_i) begin
        r_st_mie  <= r_st_mpie;
        r_st_mpie <= 1'b1;
      end else if (w_wr) begin
        unique case (1'b1)
          (csr_addr_i == CSR_MSTATUS): begin
            r_st_mie  <= w_new[MSTATUS_MIE];
            r_st_mpie <= w_new[MSTATUS_MPIE];
          end
          (csr_addr_i == CSR_MIE):
            r_mie <= w_new[NUM_IRQ-1:0];
          (csr_addr_i == CSR_MTVEC):
            r_mtvec <= w_new;
          (csr_addr_i == CSR_MSCRATCH):
            r_mscratch <= w_new;
          (csr_addr_i == CSR_MEPC):
            r_mepc <= {w_new[31:2], 2'b00};
          (csr_addr_i == CSR_MCAUSE):
            r_mcause <= w_new;
          default: ;
        endcase
      end
    end
  end

`ifdef MIRISCV_CSR_COUNTERS_EN
  miriscv_csr_counter u_mcycle (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (1'b1),
    .wr_lo_i (w_wr && csr_addr_i == CSR_MCYCLE),
    .wr_hi_i (w_wr && csr_addr_i == CSR_MCYCLEH),
    .wdata_i (w_new),
    .value_o (w_mcycle)
  );

  miriscv_csr_counter u_minstret (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (instret_i),
    .wr_lo_i (w_wr && csr_addr_i == CSR_MINSTRET),
    .wr_hi_i (w_wr && csr_addr_i == CSR_MINSTRH),
    .wdata_i (w_new),
    .value_o (w_minstret)
  );
`endif

  assign w_pend = r_mip & r_mie;

  // lowest-index enabled pending line wins
  always_comb begin
    w_irq_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pend[i]) w_irq_id = 5'(i);
    end
  end

  assign irq_req_o = r_st_mie & (|w_pend);
  assign irq_id_o  = w_irq_id;

  assign w_base = {r_mtvec[31:2], 2'b00};

  // vectored mode only applies to interrupt causes
  always_comb begin
    trap_vector_o = w_base;
    if (r_mtvec[1:0] == MTVEC_VECTORED && trap_cause_i[31])
      trap_vector_o = w_base + {25'd0, trap_cause_i[4:0], 2'b00};
  end

  assign mepc_o = r_mepc;
  assign mie_o  = w_mie32;

endmodule

// File: tb/tb_miriscv_csr_file.sv
// Scoreboard bench for miriscv_csr_file.
// Counter checks follow MIRISCV_CSR_COUNTERS_EN.
module tb_miriscv_csr_file;

  localparam int          NIRQ  = 16;
  localparam logic [31:0] MTVR  = 32'h0000_0100;
  localparam logic [31:0] HID   = 32'd3;

  localparam int S_RDATA = 0;
  localparam int S_ILL   = 1;
  localparam int S_IRQ   = 2;
  localparam int S_ID    = 3;
  localparam int S_VEC   = 4;
  localparam int S_MEPC  = 5;
  localparam int S_MIE   = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      op;
  logic [11:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            ill;
  logic            trap;
  logic [31:0]     tpc;
  logic [31:0]     tcause;
  logic            mret;
  logic [NIRQ-1:0] irq;
  logic            instret;
  logic            irq_req;
  logic [4:0]      irq_id;
  logic [31:0]     tvec;
  logic [31:0]     mepc;
  logic [31:0]     mie;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  miriscv_csr_file #(
    .NUM_IRQ     (NIRQ),
    .MTVEC_RESET (MTVR),
    .HART_ID     (HID)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .csr_op_i      (op),
    .csr_addr_i    (addr),
    .csr_wdata_i   (wdata),
    .csr_rdata_o   (rdata),
    .csr_illegal_o (ill),
    .trap_i        (trap),
    .trap_pc_i     (tpc),
    .trap_cause_i  (tcause),
    .mret_i        (mret),
    .irq_i         (irq),
    .instret_i     (instret),
    .irq_req_o     (irq_req),
    .irq_id_o      (irq_id),
    .trap_vector_o (tvec),
    .mepc_o        (mepc),
    .mie_o         (mie)
  );

  always #5 clk = ~clk;

  task automatic expect_v(input string n, input int s,
                          input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic step(input logic [1:0] o, input logic [11:0] a,
                      input logic [31:0] d);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    op      = o;
    addr    = a;
    wdata   = d;
    trap    = 1'b0;
    mret    = 1'b0;
    instret = 1'b0;
  endtask

  exp_t        m_e;
  logic [31:0] m_act;

  // monitor: compare every queued expectation mid-cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      m_e = q.pop_front();
      case (m_e.sel)
        S_RDATA: m_act = rdata;
        S_ILL:   m_act = {31'd0, ill};
        S_IRQ:   m_act = {31'd0, irq_req};
        S_ID:    m_act = {27'd0, irq_id};
        S_VEC:   m_act = tvec;
        S_MEPC:  m_act = mepc;
        default: m_act = mie;
      endcase
      n_checks++;
      if (m_act !== m_e.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h",
                 m_e.name, m_act, m_e.exp);
      end
    end
  end

  initial begin
    reset = 1'b1; op = 2'b00; addr = '0; wdata = '0;
    trap = 1'b0; tpc = '0; tcause = '0; mret = 1'b0;
    irq = '0; instret = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    reset = 1'b0;
    expect_v("rst_irq_req", S_IRQ, 0);
    expect_v("rst_ill", S_ILL, 0);
    expect_v("rst_mepc", S_MEPC, 0);
    expect_v("rst_mie", S_MIE, 0);

    step(2'b10, 12'h305, 0);
    expect_v("mtvec_rst", S_RDATA, MTVR);
    expect_v("mtvec_ill", S_ILL, 0);

    step(2'b01, 12'h304, 32'hFFFF_FFFF);
    expect_v("mie_rw_old", S_RDATA, 0);
    step(2'b11, 12'h304, 32'h0000_00F0);
    expect_v("mie_rc_old", S_RDATA, 32'h0000_FFFF);
    expect_v("mie_o_ffff", S_MIE, 32'h0000_FFFF);
    step(2'b00, 12'h304, 0);
    expect_v("mie_after_rc", S_RDATA, 32'h0000_FF0F);

    step(2'b01, 12'h304, 32'h0000_0020);
    step(2'b01, 12'h300, 32'h0000_0008);
    expect_v("mstatus_rst", S_RDATA, 32'h0000_1800);
    step(2'b00, 12'h300, 0);
    irq[5] = 1'b1;
    expect_v("mstatus_mie", S_RDATA, 32'h0000_1808);
    expect_v("irq_lat0", S_IRQ, 0);
    step(2'b00, 12'h300, 0);
    irq[5] = 1'b0;
    expect_v("irq_lat1", S_IRQ, 1);
    expect_v("irq_id5", S_ID, 5);

    step(2'b01, 12'h305, 32'h0000_0201);
    irq[5] = 1'b1;
    expect_v("irq_pulse_gone", S_IRQ, 0);
    step(2'b01, 12'h340, 32'h0000_1234);
    trap = 1'b1; tpc = 32'h100; tcause = 32'h8000_0005;
    expect_v("pretrap_irq", S_IRQ, 1);
    expect_v("vec_0x214", S_VEC, 32'h0000_0214);
    expect_v("mscratch_old", S_RDATA, 0);
    step(2'b00, 12'h300, 0);
    tcause = 32'h0000_0005;
    expect_v("trap_mstatus", S_RDATA, 32'h0000_1880);
    expect_v("trap_mepc", S_MEPC, 32'h0000_0100);
    expect_v("trap_irq_drop", S_IRQ, 0);
    expect_v("vec_direct", S_VEC, 32'h0000_0200);
    step(2'b00, 12'h342, 0);
    tcause = 32'h8000_0003;
    expect_v("trap_mcause", S_RDATA, 32'h8000_0005);
    expect_v("vec_0x20c", S_VEC, 32'h0000_020C);
    step(2'b00, 12'h340, 0);
    expect_v("mscratch_kept", S_RDATA, 0);

    step(2'b01, 12'h340, 32'h0000_0055);
    mret = 1'b1;
    step(2'b00, 12'h300, 0);
    expect_v("mret_mstatus", S_RDATA, 32'h0000_1888);
    expect_v("mret_irq", S_IRQ, 1);
    step(2'b00, 12'h340, 0);
    expect_v("mret_nowrite", S_RDATA, 0);

    step(2'b01, 12'h7C0, 32'h0000_DEAD);
    expect_v("bad_ill", S_ILL, 1);
    expect_v("bad_rdata", S_RDATA, 0);
    step(2'b00, 12'h7C0, 0);
    expect_v("bad_noop", S_ILL, 0);

    step(2'b01, 12'h341, 32'h0000_0203);
    expect_v("mepc_old", S_RDATA, 32'h0000_0100);
    step(2'b00, 12'h341, 0);
    expect_v("mepc_align", S_RDATA, 32'h0000_0200);
    expect_v("mepc_o_align", S_MEPC, 32'h0000_0200);

    step(2'b01, 12'h344, 0);
    expect_v("mip_ro_ill", S_ILL, 0);
    expect_v("mip_read", S_RDATA, 32'h0000_0020);
    step(2'b00, 12'h344, 0);
    expect_v("mip_kept", S_RDATA, 32'h0000_0020);
    step(2'b01, 12'hF14, 32'h55);
    expect_v("hartid", S_RDATA, HID);
    expect_v("hartid_ill", S_ILL, 0);

    step(2'b01, 12'h340, 32'h9);
    irq = '0;
    reset = 1'b1; trap = 1'b1; tpc = 32'h444;
    step(2'b00, 12'h300, 0);
    expect_v("mrst_mstatus", S_RDATA, 32'h0000_1800);
    expect_v("mrst_mepc", S_MEPC, 0);
    expect_v("mrst_mie", S_MIE, 0);
    expect_v("mrst_irq", S_IRQ, 0);
    step(2'b00, 12'h305, 0);
    expect_v("mrst_mtvec", S_RDATA, MTVR);

`ifdef MIRISCV_CSR_COUNTERS_EN
    step(2'b01, 12'hB00, 32'hFFFF_FFFF);
    expect_v("mcyc_ill", S_ILL, 0);
    step(2'b01, 12'hB80, 32'hFFFF_FFFF);
    step(2'b00, 12'hB00, 0);
    expect_v("mcyc_lo_max", S_RDATA, 32'hFFFF_FFFF);
    step(2'b00, 12'hB80, 0);
    expect_v("mcyc_hi_wrap", S_RDATA, 0);
    step(2'b00, 12'hB00, 0);
    expect_v("mcyc_lo_wrap", S_RDATA, 1);

    step(2'b01, 12'hB02, 0);
    step(2'b01, 12'hB82, 0);
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 12'h300, 0);
      instret = 1'b1;
    end
    step(2'b00, 12'hB02, 0);
    expect_v("minstret_3", S_RDATA, 3);
    step(2'b00, 12'hB82, 0);
    expect_v("minstreth_0", S_RDATA, 0);
`else
    step(2'b01, 12'hB00, 32'h1);
    expect_v("mcyc_off_ill", S_ILL, 1);
    expect_v("mcyc_off_rd", S_RDATA, 0);
    step(2'b10, 12'hB82, 0);
    instret = 1'b1;
    expect_v("minsth_off_ill", S_ILL, 1);
`endif

    step(2'b00, 12'h000, 0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
